tdnn_sched: RTL and testbench
=============================

# tdnn_sched

Sequencing controller for the TDNN datapath on the slide-switch/seven-segment board build. After reset it streams the weight set from a weight memory into the TDNN write-back port. It then samples the switch input at a fixed rate into a NUM_INPUTS-deep delay line, kicks one TDNN evaluation per sample, and latches the two signal outputs for the Seg7 display. It replaces the constant write-back enable in the top level with a real load phase and adds overrun/error reporting.

## Interface
- SIG_SIZE, 16, sample and result width
- WEIGHT_SIZE, 16, weight word width
- NUM_INPUTS, 3, delay-line taps per sample window
- NUM_SIGS, 2, TDNN output channels; weight count NW = NUM_INPUTS*NUM_SIGS
- TICK_DIV, 100000, topclk cycles per sample tick (>= 2)
- WDT_CYCLES, 255, watchdog limit (only with TDNN_SCHED_WDT_EN)

- topclk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- sw_in  in  SIG_SIZE  switch sample
- reload  in  1  pulse: re-run the weight load
- wmem_rd  out  1  weight memory read strobe
- wmem_addr  out  $clog2(NW)  weight memory address
- wmem_data  in  WEIGHT_SIZE  read data, valid one cycle after wmem_rd
- wb_en  out  1  TDNN weight write enable
- wb_addr  out  $clog2(NW)  TDNN weight index
- wb_data  out  WEIGHT_SIZE  TDNN weight value
- taps  out  NUM_INPUTS*SIG_SIZE  delay line, tap 0 (LSBs) newest
- start  out  1  one-cycle evaluate pulse
- done  in  1  TDNN result valid
- sig_res1, sig_res2  in  SIG_SIZE  TDNN results
- disp1, disp2  out  SIG_SIZE  latched results for Seg7
- res_valid  out  1  one-cycle pulse on latch
- loaded  out  1  high once a full weight set has been written
- overrun  out  1  sticky: a tick arrived while busy
- timeout  out  1  sticky watchdog flag (0 when the watchdog is compiled out)

## Operation
- States: LOAD_RD, LOAD_WR, WAIT_TICK, START, WAIT_DONE, LATCH.
- Reset: all outputs, taps, counters and sticky flags are 0, and the state is LOAD_RD with index 0. The load starts automatically on reset release.
- LOAD_RD: wmem_rd=1, wmem_addr=idx, then go to LOAD_WR.
- LOAD_WR: wb_en=1, wb_addr=idx, wb_data=wmem_data.
  - If idx==NW-1: set loaded, clear idx, go to WAIT_TICK.
  - Otherwise: idx+1, go to LOAD_RD.
- WAIT_TICK:
  - reload: clear loaded, go to LOAD_RD.
  - Else tick: shift the taps (tap0<=sw_in, tap k<=tap k-1), go to START.
- START: start=1 for one cycle, go to WAIT_DONE.
- WAIT_DONE: wait for done==1, then go to LATCH.
- LATCH: disp1<=sig_res1, disp2<=sig_res2, res_valid=1, go to WAIT_TICK.
- Tick generator: counter runs freely from reset, wraps modulo TICK_DIV, and tick=1 when count==TICK_DIV-1.
- A tick arriving in START, WAIT_DONE or LATCH sets overrun and the sample is dropped; taps are unchanged.
- A tick arriving during LOAD_RD/LOAD_WR is dropped silently, with no overrun.
- reload and tick in the same WAIT_TICK cycle: reload wins, the tick is dropped and no overrun is set. reload outside WAIT_TICK is ignored.
- done outside WAIT_DONE is ignored.
- Taps and disp1/disp2 are kept across reload; only reset clears them.
- Sticky flags are cleared only by reset.

## Timing
- Weight load takes 2*NW cycles (12 at defaults). loaded rises on the cycle after the final LOAD_WR.
- Tick to start: start is asserted 1 cycle after the tick cycle. Taps update on the same edge that enters START.
- done to res_valid: 1 cycle. disp1/disp2 update on the same edge.
- Minimum tick-to-tick service time: 3 cycles plus the done latency.
- Asynchronous reset asserted mid-load or mid-evaluation returns every output to 0 immediately. A partial weight set is not resumed; the load restarts from idx 0.

## Configuration
- TDNN_SCHED_WDT_EN defined:
  - An 8+ bit counter clears on entering WAIT_DONE.
  - If WDT_CYCLES cycles elapse without done: set timeout, skip LATCH (no res_valid, disp unchanged), go to WAIT_TICK.
- Not defined: WAIT_DONE waits indefinitely and timeout is tied to 0.

## Test plan
- Reset release, wmem holding 0x0011..0x0066 at addr 0..5 -> wb_en pulses on cycles 2,4,...,12 with wb_addr 0..5 and matching data; loaded=1 at cycle 13.
- TICK_DIV=20, sw_in=0x1234 then 0x5678 on successive ticks -> taps = {0,0x1234,0x5678} (tap0=0x5678). start pulses once per tick.
- done returned 3 cycles after start with sig_res1=0xBEEF, sig_res2=0x0042 -> res_valid 1 cycle after done, disp1=0xBEEF, disp2=0x0042.
- done withheld for 25 cycles with TICK_DIV=20 -> overrun=1 and taps unchanged by the dropped tick; with TDNN_SCHED_WDT_EN and WDT_CYCLES=10 instead -> timeout=1 and disp unchanged.
- reload coincident with tick in WAIT_TICK -> load restarts at addr 0, no start, overrun stays 0, taps retained.
- reset asserted during LOAD_WR of idx 3 -> all outputs 0 at once; after release, the load reruns from idx 0.

Source files
------------

// File: rtl/tdnn_sched.sv
// Sequencing controller for the TDNN datapath: weight load, sampled delay line, evaluate/latch.
// Optional watchdog on the done handshake is enabled with TDNN_SCHED_WDT_EN.
module tdnn_sched #(
    parameter int SIG_SIZE    = 16,
    parameter int WEIGHT_SIZE = 16,
    parameter int NUM_INPUTS  = 3,
    parameter int NUM_SIGS    = 2,
    parameter int TICK_DIV    = 100000,
    parameter int WDT_CYCLES  = 255
) (
    input  logic                                     topclk,
    input  logic                                     reset,
    input  logic [SIG_SIZE-1:0]                      sw_in,
    input  logic                                     reload,
    output logic                                     wmem_rd,
    output logic [$clog2(NUM_INPUTS*NUM_SIGS)-1:0]   wmem_addr,
    input  logic [WEIGHT_SIZE-1:0]                   wmem_data,
    output logic                                     wb_en,
    output logic [$clog2(NUM_INPUTS*NUM_SIGS)-1:0]   wb_addr,
    output logic [WEIGHT_SIZE-1:0]                   wb_data,
    output logic [NUM_INPUTS*SIG_SIZE-1:0]           taps,
    output logic                                     start,
    input  logic                                     done,
    input  logic [SIG_SIZE-1:0]                      sig_res1,
    input  logic [SIG_SIZE-1:0]                      sig_res2,
    output logic [SIG_SIZE-1:0]                      disp1,
    output logic [SIG_SIZE-1:0]                      disp2,
    output logic                                     res_valid,
    output logic                                     loaded,
    output logic                                     overrun,
    output logic                                     timeout
);

    localparam int NW   = NUM_INPUTS * NUM_SIGS;
    localparam int AW   = $clog2(NW);
    localparam int TW   = $clog2(TICK_DIV);
    localparam int TAPW = NUM_INPUTS * SIG_SIZE;

    typedef enum logic [2:0] {
        LOAD_RD,
        LOAD_WR,
        WAIT_TICK,
        START,
        WAIT_DONE,
        LATCH
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          shift, do_latch, set_loaded, clr_loaded, set_overrun;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge topclk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

`ifdef TDNN_SCHED_WDT_EN
    localparam int WDW = ($clog2(WDT_CYCLES + 1) > 8) ? $clog2(WDT_CYCLES + 1) : 8;

    logic [WDW-1:0] wdt_cnt;
    logic           wdt_expired;
    logic           timeout_q;

    assign wdt_expired = (wdt_cnt == WDW'(WDT_CYCLES - 1));
    assign timeout     = timeout_q;

    // Held at zero outside WAIT_DONE, so it is clear on every entry.
    always_ff @(posedge topclk or posedge reset) begin
        if (reset) begin
            wdt_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != WAIT_DONE) begin
                wdt_cnt <= '0;
            end else begin
                wdt_cnt <= wdt_cnt + WDW'(1);
            end
            if (state == WAIT_DONE && !done && wdt_expired) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        shift       = 1'b0;
        do_latch    = 1'b0;
        set_loaded  = 1'b0;
        clr_loaded  = 1'b0;
        set_overrun = 1'b0;
        case (state)
            LOAD_RD: state_n = LOAD_WR;
            LOAD_WR: begin
                if (idx == AW'(NW - 1)) begin
                    idx_n      = '0;
                    set_loaded = 1'b1;
                    state_n    = WAIT_TICK;
                end else begin
                    idx_n   = idx + AW'(1);
                    state_n = LOAD_RD;
                end
            end
            WAIT_TICK: begin
                if (reload) begin
                    clr_loaded = 1'b1;
                    state_n    = LOAD_RD;
                end else if (tick) begin
                    shift   = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                set_overrun = tick;
                state_n     = WAIT_DONE;
            end
            WAIT_DONE: begin
                set_overrun = tick;
                if (done) begin
                    state_n = LATCH;
                end
`ifdef TDNN_SCHED_WDT_EN
                else if (wdt_expired) begin
                    state_n = WAIT_TICK;
                end
`endif
            end
            LATCH: begin
                set_overrun = tick;
                do_latch    = 1'b1;
                state_n     = WAIT_TICK;
            end
            default: state_n = LOAD_RD;
        endcase
    end

    always_ff @(posedge topclk or posedge reset) begin
        if (reset) begin
            state   <= LOAD_RD;
            idx     <= '0;
            taps    <= '0;
            disp1   <= '0;
            disp2   <= '0;
            loaded  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (shift) begin
                taps <= {taps[TAPW-SIG_SIZE-1:0], sw_in};
            end
            if (do_latch) begin
                disp1 <= sig_res1;
                disp2 <= sig_res2;
            end
            if (set_loaded) begin
                loaded <= 1'b1;
            end else if (clr_loaded) begin
                loaded <= 1'b0;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

    // The reset state is LOAD_RD, so the read strobe is masked while reset is held.
    assign wmem_rd   = !reset && (state == LOAD_RD);
    assign wmem_addr = wmem_rd ? idx : '0;
    assign wb_en     = (state == LOAD_WR);
    assign wb_addr   = wb_en ? idx : '0;
    assign wb_data   = wb_en ? wmem_data : '0;
    assign start     = (state == START);
    assign res_valid = (state == LATCH);

endmodule

// File: tb/tb_tdnn_sched.sv
// Self-checking bench for tdnn_sched: directed load/tick/reload/overrun/reset cases,
// then randomized traffic compared every cycle against a behavioural model.
module tb_tdnn_sched;

    localparam int SS = 16;
    localparam int WS = 16;
    localparam int NI = 3;
    localparam int NS = 2;
    localparam int NW = NI * NS;
    localparam int AW = $clog2(NW);
    localparam int TD = 20;
    localparam int WD = 10;

    logic              topclk = 1'b0;
    logic              reset;
    logic [SS-1:0]     sw_in;
    logic              reload;
    logic              wmem_rd;
    logic [AW-1:0]     wmem_addr;
    logic [WS-1:0]     wmem_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [WS-1:0]     wb_data;
    logic [NI*SS-1:0]  taps;
    logic              start;
    logic              done;
    logic [SS-1:0]     sig_res1, sig_res2;
    logic [SS-1:0]     disp1, disp2;
    logic              res_valid, loaded, overrun, timeout;

    tdnn_sched #(
        .SIG_SIZE    (SS),
        .WEIGHT_SIZE (WS),
        .NUM_INPUTS  (NI),
        .NUM_SIGS    (NS),
        .TICK_DIV    (TD),
        .WDT_CYCLES  (WD)
    ) dut (
        .topclk    (topclk),
        .reset     (reset),
        .sw_in     (sw_in),
        .reload    (reload),
        .wmem_rd   (wmem_rd),
        .wmem_addr (wmem_addr),
        .wmem_data (wmem_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .taps      (taps),
        .start     (start),
        .done      (done),
        .sig_res1  (sig_res1),
        .sig_res2  (sig_res2),
        .disp1     (disp1),
        .disp2     (disp2),
        .res_valid (res_valid),
        .loaded    (loaded),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 topclk = ~topclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [WS-1:0] mem [NW];

    // Behavioural model: load position, evaluation progress and the sample window.
    bit            m_ld, m_loaded, m_eval, m_latch, m_ovr, m_tmo;
    int            m_step, m_age, m_tcnt;
    logic [SS-1:0] m_tap [NI];
    logic [SS-1:0] m_d1, m_d2;

    task automatic model_reset();
        m_ld = 1; m_step = 0; m_loaded = 0; m_eval = 0; m_latch = 0;
        m_age = 0; m_ovr = 0; m_tmo = 0; m_tcnt = 0; m_d1 = '0; m_d2 = '0;
        for (int k = 0; k < NI; k++) m_tap[k] = '0;
    endtask

    task automatic model_step();
        bit tk;
        tk = (m_tcnt == TD - 1);
        if (m_ld) begin
            if (m_step == 2 * NW - 1) begin
                m_ld = 0; m_loaded = 1;
            end else begin
                m_step++;
            end
        end else if (!m_eval) begin
            if (reload) begin
                m_ld = 1; m_step = 0; m_loaded = 0;
            end else if (tk) begin
                for (int k = NI - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
                m_tap[0] = sw_in;
                m_eval = 1; m_age = 0; m_latch = 0;
            end
        end else begin
            if (tk) m_ovr = 1;
            if (m_latch) begin
                m_d1 = sig_res1; m_d2 = sig_res2; m_eval = 0; m_latch = 0;
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (done) begin
                m_latch = 1;
            end
`ifdef TDNN_SCHED_WDT_EN
            else if (m_age == WD) begin
                m_tmo = 1; m_eval = 0;
            end
`endif
            else begin
                m_age++;
            end
        end
        m_tcnt = (m_tcnt + 1) % TD;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge topclk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin
        bit en, e_rd, e_wr;
        forever begin
            @(negedge topclk);
            en   = !reset;
            e_rd = en && m_ld && (m_step % 2 == 0);
            e_wr = en && m_ld && (m_step % 2 == 1);
            chk("wmem_rd",   64'(wmem_rd),   64'(e_rd));
            chk("wmem_addr", 64'(wmem_addr), e_rd ? 64'(m_step / 2) : 64'(0));
            chk("wb_en",     64'(wb_en),     64'(e_wr));
            chk("wb_addr",   64'(wb_addr),   e_wr ? 64'(m_step / 2) : 64'(0));
            chk("wb_data",   64'(wb_data),   e_wr ? 64'(mem[m_step / 2]) : 64'(0));
            chk("start",     64'(start),     64'(en && m_eval && !m_latch && m_age == 0));
            chk("res_valid", 64'(res_valid), 64'(en && m_eval && m_latch));
            chk("taps",      64'(taps),      64'({m_tap[2], m_tap[1], m_tap[0]}));
            chk("disp1",     64'(disp1),     64'(m_d1));
            chk("disp2",     64'(disp2),     64'(m_d2));
            chk("loaded",    64'(loaded),    64'(m_loaded));
            chk("overrun",   64'(overrun),   64'(m_ovr));
            chk("timeout",   64'(timeout),   64'(m_tmo));
        end
    end

    // Stimulus: memory responder, TDNN done responder and directed/random drive.
    int            cyc = 0;
    int            pend = -1;
    int            done_delay = 3;
    bit            fixed_res = 1, spur = 0;
    logic [SS-1:0] r1v = 16'hBEEF, r2v = 16'h0042;

    task automatic step_cycle();
        bit            st, rd_s;
        logic [AW-1:0] ad_s;
        @(negedge topclk);
        st = start; rd_s = wmem_rd; ad_s = wmem_addr;
        @(posedge topclk);
        #1;
        cyc++;
        reload    = 1'b0;
        wmem_data = rd_s ? mem[ad_s] : WS'($urandom);
        done      = 1'b0;
        if (st) pend = done_delay - 1;
        else if (pend > 0) pend--;
        if (pend == 0) begin
            done = 1'b1; pend = -1;
            sig_res1 = fixed_res ? r1v : SS'($urandom);
            sig_res2 = fixed_res ? r2v : SS'($urandom);
        end else if (spur && !st && pend < 0 && $urandom_range(0, 15) == 0) begin
            done = 1'b1;
            sig_res1 = SS'($urandom);
            sig_res2 = SS'($urandom);
        end
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step_cycle();
    endtask

    task automatic release_reset();
        @(posedge topclk);
        #1;
        reset = 1'b0;
        cyc   = 1;
        #1;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < NW; i++) mem[i] = WS'(16'h0011 * (i + 1));
        reset = 1'b1; sw_in = 16'h1234; reload = 1'b0; done = 1'b0;
        sig_res1 = '0; sig_res2 = '0; wmem_data = '0;
        repeat (3) @(posedge topclk);
        release_reset();

        chk("c1_wmem_rd", 64'(wmem_rd), 64'(1));
        chk("c1_wmem_addr", 64'(wmem_addr), 64'(0));
        run_to(2);
        chk("c2_wb_en", 64'(wb_en), 64'(1));
        chk("c2_wb_addr", 64'(wb_addr), 64'(0));
        chk("c2_wb_data", 64'(wb_data), 64'(16'h0011));
        run_to(12);
        chk("c12_wb_addr", 64'(wb_addr), 64'(5));
        chk("c12_wb_data", 64'(wb_data), 64'(16'h0066));
        chk("c12_loaded", 64'(loaded), 64'(0));
        run_to(13);
        chk("c13_loaded", 64'(loaded), 64'(1));

        run_to(21);
        chk("c21_start", 64'(start), 64'(1));
        chk("c21_taps", 64'(taps), 64'(48'h0000_0000_1234));
        run_to(25);
        chk("c25_res_valid", 64'(res_valid), 64'(1));
        run_to(26);
        chk("c26_disp1", 64'(disp1), 64'(16'hBEEF));
        chk("c26_disp2", 64'(disp2), 64'(16'h0042));
        sw_in = 16'h5678;
        run_to(41);
        chk("c41_start", 64'(start), 64'(1));
        chk("c41_taps", 64'(taps), 64'(48'h0000_1234_5678));

        run_to(60);
        reload = 1'b1;
        run_to(61);
        chk("rl_start", 64'(start), 64'(0));
        chk("rl_wmem_rd", 64'(wmem_rd), 64'(1));
        chk("rl_wmem_addr", 64'(wmem_addr), 64'(0));
        chk("rl_loaded", 64'(loaded), 64'(0));
        chk("rl_overrun", 64'(overrun), 64'(0));
        chk("rl_taps", 64'(taps), 64'(48'h0000_1234_5678));
        sw_in = 16'h9ABC; done_delay = 25; r1v = 16'h1111; r2v = 16'h2222;
        run_to(73);
        chk("rl_loaded_again", 64'(loaded), 64'(1));
        run_to(81);
        chk("c81_start", 64'(start), 64'(1));
        sw_in = 16'hDEAD;
`ifdef TDNN_SCHED_WDT_EN
        run_to(93);
        chk("wdt_timeout", 64'(timeout), 64'(1));
        chk("wdt_disp1", 64'(disp1), 64'(16'hBEEF));
        run_to(101);
        chk("wdt_taps", 64'(taps), 64'(48'h5678_9ABC_DEAD));
        chk("wdt_overrun", 64'(overrun), 64'(0));
`else
        run_to(101);
        chk("ovr_overrun", 64'(overrun), 64'(1));
        chk("ovr_taps", 64'(taps), 64'(48'h1234_5678_9ABC));
        chk("ovr_disp1", 64'(disp1), 64'(16'hBEEF));
        chk("ovr_timeout", 64'(timeout), 64'(0));
`endif

        fixed_res = 0; spur = 1;
        repeat (3000) begin
            step_cycle();
            sw_in      = SS'($urandom);
            reload     = ($urandom_range(0, 63) == 0);
            done_delay = $urandom_range(1, 22);
        end

        spur = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step_cycle();
            if (m_ld && m_step == 7) found = 1;
            else reload = !m_ld && !m_eval;
        end
        reload = 1'b0;
        chk("find_load_wr3", 64'(found), 64'(1));
        #2;
        reset = 1'b1;
        pend  = -1;
        done  = 1'b0;
        #1;
        chk("rst_wmem_rd", 64'(wmem_rd), 64'(0));
        chk("rst_wb_en", 64'(wb_en), 64'(0));
        chk("rst_wb_addr", 64'(wb_addr), 64'(0));
        chk("rst_wb_data", 64'(wb_data), 64'(0));
        chk("rst_taps", 64'(taps), 64'(0));
        chk("rst_disp1", 64'(disp1), 64'(0));
        chk("rst_disp2", 64'(disp2), 64'(0));
        chk("rst_loaded", 64'(loaded), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));
        chk("rst_timeout", 64'(timeout), 64'(0));
        chk("rst_start", 64'(start), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        repeat (2) @(posedge topclk);
        release_reset();
        chk("rr_wmem_rd", 64'(wmem_rd), 64'(1));
        chk("rr_wmem_addr", 64'(wmem_addr), 64'(0));
        run_to(2);
        chk("rr_wb_en", 64'(wb_en), 64'(1));
        chk("rr_wb_addr", 64'(wb_addr), 64'(0));
        chk("rr_wb_data", 64'(wb_data), 64'(16'h0011));
        run_to(13);
        chk("rr_loaded", 64'(loaded), 64'(1));
        run_to(16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
